// File: rtl/sbox_scheduler.sv
// Time-multiplexes one 32-bit S-box lane between 128-bit SubBytes and 32-bit SubWord requests.
// Optional macro SBOX_SCHED_PIPE_EN registers sbox_out, adding one drain cycle per job.
module sbox_scheduler (
   input  logic         clk,
   input  logic         rst,
   input  logic         st_req_valid,
   output logic         st_req_ready,
   input  logic [127:0] st_req_data,
   output logic         st_rsp_valid,
   output logic [127:0] st_rsp_data,
   input  logic         kw_req_valid,
   output logic         kw_req_ready,
   input  logic [31:0]  kw_req_data,
   output logic         kw_rsp_valid,
   output logic [31:0]  kw_rsp_data,
   output logic [31:0]  sbox_in,
   input  logic [31:0]  sbox_out,
   output logic         busy
);

   typedef enum logic [1:0] {StIdle, StStRun, StKwRun} state_e;
   typedef enum logic {GrantState, GrantKey} grant_e;

   state_e         state_q, state_d;
   grant_e         last_grant_q, last_grant_d;
   logic [2:0]     pass_q, pass_d;
   logic [127:0]   buf_q, buf_d;
   logic           st_rsp_valid_q, st_rsp_valid_d;
   logic           kw_rsp_valid_q, kw_rsp_valid_d;
   logic [127:0]   st_rsp_data_q, st_rsp_data_d;
   logic [31:0]    kw_rsp_data_q, kw_rsp_data_d;
   logic [31:0]    cap;
   logic           cap_en;
   logic [2:0]     cap_idx;

`ifdef SBOX_SCHED_PIPE_EN
   localparam logic [2:0] Drain = 3'd1;
   logic [31:0] pipe_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= sbox_out;
   end

   assign cap    = pipe_q;
   assign cap_en = (pass_q != 3'd0);
`else
   localparam logic [2:0] Drain = 3'd0;
   assign cap    = sbox_out;
   assign cap_en = 1'b1;
`endif

   localparam logic [2:0] LastPass = 3'd3 + Drain;

   assign cap_idx = pass_q - Drain;

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      pass_d         = pass_q;
      buf_d          = buf_q;
      st_rsp_valid_d = 1'b0;
      kw_rsp_valid_d = 1'b0;
      st_rsp_data_d  = st_rsp_data_q;
      kw_rsp_data_d  = kw_rsp_data_q;
      sbox_in        = '0;
      st_req_ready   = 1'b0;
      kw_req_ready   = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Readies are gated by rst so nothing looks acceptable while held in reset.
            kw_req_ready = !rst && !(st_req_valid && last_grant_q == GrantKey);
            st_req_ready = !rst && !(kw_req_valid && last_grant_q == GrantState);
            pass_d       = '0;
            if (kw_req_valid && kw_req_ready) begin
               buf_d[127:96] = kw_req_data;
               last_grant_d  = GrantKey;
               state_d       = StKwRun;
            end else if (st_req_valid && st_req_ready) begin
               buf_d        = st_req_data;
               last_grant_d = GrantState;
               state_d      = StStRun;
            end
         end
         StStRun: begin
            pass_d = pass_q + 3'd1;
            // Results overwrite their source slice in place; that slice is no longer needed.
            for (int i = 0; i < 4; i++) begin
               if (pass_q == 3'(i)) sbox_in = buf_q[127-32*i -: 32];
               if (cap_en && cap_idx == 3'(i)) buf_d[127-32*i -: 32] = cap;
            end
            if (pass_q == LastPass) begin
               st_rsp_valid_d = 1'b1;
               st_rsp_data_d  = buf_d;
               pass_d         = '0;
               state_d        = StIdle;
            end
         end
         StKwRun: begin
            pass_d = pass_q + 3'd1;
            if (pass_q == 3'd0) sbox_in = buf_q[127:96];
            if (pass_q == Drain) begin
               kw_rsp_valid_d = 1'b1;
               kw_rsp_data_d  = cap;
               pass_d         = '0;
               state_d        = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         last_grant_q   <= GrantState;
         pass_q         <= '0;
         buf_q          <= '0;
         st_rsp_valid_q <= 1'b0;
         kw_rsp_valid_q <= 1'b0;
         st_rsp_data_q  <= '0;
         kw_rsp_data_q  <= '0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         pass_q         <= pass_d;
         buf_q          <= buf_d;
         st_rsp_valid_q <= st_rsp_valid_d;
         kw_rsp_valid_q <= kw_rsp_valid_d;
         st_rsp_data_q  <= st_rsp_data_d;
         kw_rsp_data_q  <= kw_rsp_data_d;
      end
   end

   assign st_rsp_valid = st_rsp_valid_q;
   assign kw_rsp_valid = kw_rsp_valid_q;
   assign st_rsp_data  = st_rsp_data_q;
   assign kw_rsp_data  = kw_rsp_data_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_sbox_scheduler.sv
// Self-checking bench for sbox_scheduler with an AES S-box lane model and response scoreboards.
module tb_sbox_scheduler;

`ifdef SBOX_SCHED_PIPE_EN
   localparam int StLat = 5;
   localparam int KwLat = 2;
`else
   localparam int StLat = 4;
   localparam int KwLat = 1;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         st_req_valid, st_req_ready;
   logic [127:0] st_req_data;
   logic         st_rsp_valid;
   logic [127:0] st_rsp_data;
   logic         kw_req_valid, kw_req_ready;
   logic [31:0]  kw_req_data;
   logic         kw_rsp_valid;
   logic [31:0]  kw_rsp_data;
   logic [31:0]  sbox_in, sbox_out;
   logic         busy;

   int errors = 0;
   int checks = 0;
   int st_cnt = 0;
   int kw_cnt = 0;
   logic [127:0] st_exp_q[$];
   logic [31:0]  kw_exp_q[$];
   bit           order_q[$];   // 1 = key response, 0 = state response

   logic [127:0] v_st     = 128'h4f637606_43e0aa85_efa72132_01a4e705;
   logic [127:0] v_st_exp = 128'h84fb386f_1ae1ac97_df5cfd23_7c49946b;
   logic [31:0]  v_kw     = 32'hcf4f3c09;
   logic [31:0]  v_kw_exp = 32'h8a84eb01;

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox8(input logic [7:0] x);
      logic [7:0] r, s;
      r = 8'h01;
      if (x == 8'h00) r = 8'h00;
      else for (int i = 0; i < 254; i++) r = gmul(r, x);
      s = r ^ ((r << 1) | (r >> 7)) ^ ((r << 2) | (r >> 6)) ^ ((r << 3) | (r >> 5))
          ^ ((r << 4) | (r >> 4)) ^ 8'h63;
      return s;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox8(w[31:24]), sbox8(w[23:16]), sbox8(w[15:8]), sbox8(w[7:0])};
   endfunction

   function automatic logic [127:0] sub_state(input logic [127:0] s);
      return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
   endfunction

   assign sbox_out = sub_word(sbox_in);

   sbox_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .st_req_valid (st_req_valid),
      .st_req_ready (st_req_ready),
      .st_req_data  (st_req_data),
      .st_rsp_valid (st_rsp_valid),
      .st_rsp_data  (st_rsp_data),
      .kw_req_valid (kw_req_valid),
      .kw_req_ready (kw_req_ready),
      .kw_req_data  (kw_req_data),
      .kw_rsp_valid (kw_rsp_valid),
      .kw_rsp_data  (kw_rsp_data),
      .sbox_in      (sbox_in),
      .sbox_out     (sbox_out),
      .busy         (busy)
   );

   // Scoreboard: pops the expected result whenever a response pulse is seen.
   always @(negedge clk) begin
      if (!rst) begin
         if (st_rsp_valid) begin
            st_cnt++;
            order_q.push_back(1'b0);
            checks++;
            if (st_exp_q.size() == 0) begin
               errors++;
               $display("FAIL st_rsp_unexpected: got %h, none expected", st_rsp_data);
            end else begin
               logic [127:0] e;
               e = st_exp_q.pop_front();
               if (st_rsp_data !== e) begin
                  errors++;
                  $display("FAIL st_rsp_data: got %h, want %h", st_rsp_data, e);
               end
            end
         end
         if (kw_rsp_valid) begin
            kw_cnt++;
            order_q.push_back(1'b1);
            checks++;
            if (kw_exp_q.size() == 0) begin
               errors++;
               $display("FAIL kw_rsp_unexpected: got %h, none expected", kw_rsp_data);
            end else begin
               logic [31:0] e;
               e = kw_exp_q.pop_front();
               if (kw_rsp_data !== e) begin
                  errors++;
                  $display("FAIL kw_rsp_data: got %h, want %h", kw_rsp_data, e);
               end
            end
         end
      end
   end

   task automatic test_reset;
      rst = 1'b1;
      st_req_valid = 1'b0; kw_req_valid = 1'b0;
      st_req_data = '0; kw_req_data = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({st_req_ready, kw_req_ready} !== 2'b00) begin
         errors++; $display("FAIL reset_ready: got %b, want 00", {st_req_ready, kw_req_ready});
      end
      checks++;
      if ({st_rsp_valid, kw_rsp_valid, busy} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b, want 000", {st_rsp_valid, kw_rsp_valid, busy});
      end
      checks++;
      if (st_rsp_data !== 128'h0 || kw_rsp_data !== 32'h0 || sbox_in !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got st=%h kw=%h in=%h, want zeros", st_rsp_data, kw_rsp_data,
                  sbox_in);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({st_req_ready, kw_req_ready} !== 2'b11) begin
         errors++; $display("FAIL idle_ready: got %b, want 11", {st_req_ready, kw_req_ready});
      end
   endtask

   task automatic test_single_state;
      logic [127:0] d;
      int n;
      d = v_st;
      n = st_cnt;
      @(negedge clk);
      st_req_valid = 1'b1; st_req_data = d;
      #1;
      checks++;
      if (st_req_ready !== 1'b1) begin
         errors++; $display("FAIL st_accept_ready: got %b, want 1", st_req_ready);
      end
      @(posedge clk);
      st_exp_q.push_back(v_st_exp);
      for (int c = 1; c <= StLat + 1; c++) begin
         logic [31:0] want_in;
         @(negedge clk);
         st_req_valid = 1'b0;
         #1;
         want_in = (c <= 4) ? d[127-32*(c-1) -: 32] : 32'h0;
         checks++;
         if (sbox_in !== want_in) begin
            errors++; $display("FAIL st_sbox_in c%0d: got %h, want %h", c, sbox_in, want_in);
         end
         checks++;
         if (st_rsp_valid !== (c == StLat + 1) || busy !== (c != StLat + 1)) begin
            errors++;
            $display("FAIL st_timing c%0d: got valid=%b busy=%b", c, st_rsp_valid, busy);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (st_rsp_valid !== 1'b0 || st_rsp_data !== v_st_exp || st_cnt != n + 1) begin
         errors++;
         $display("FAIL st_hold: got valid=%b data=%h cnt=%0d, want 0 %h %0d", st_rsp_valid,
                  st_rsp_data, st_cnt, v_st_exp, n + 1);
      end
   endtask

   task automatic test_single_key;
      @(negedge clk);
      kw_req_valid = 1'b1; kw_req_data = v_kw;
      #1;
      checks++;
      if (kw_req_ready !== 1'b1) begin
         errors++; $display("FAIL kw_accept_ready: got %b, want 1", kw_req_ready);
      end
      @(posedge clk);
      kw_exp_q.push_back(v_kw_exp);
      for (int c = 1; c <= KwLat + 1; c++) begin
         logic [31:0] want_in;
         @(negedge clk);
         kw_req_valid = 1'b0;
         #1;
         want_in = (c == 1) ? v_kw : 32'h0;
         checks++;
         if (sbox_in !== want_in) begin
            errors++; $display("FAIL kw_sbox_in c%0d: got %h, want %h", c, sbox_in, want_in);
         end
         checks++;
         if (kw_rsp_valid !== (c == KwLat + 1) || busy !== (c != KwLat + 1)) begin
            errors++;
            $display("FAIL kw_timing c%0d: got valid=%b busy=%b", c, kw_rsp_valid, busy);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (kw_rsp_valid !== 1'b0 || kw_rsp_data !== v_kw_exp || st_rsp_data !== v_st_exp) begin
         errors++;
         $display("FAIL kw_hold: got valid=%b kw=%h st=%h", kw_rsp_valid, kw_rsp_data, st_rsp_data);
      end
   endtask

   task automatic test_tie_after_reset;
      int cyc;
      bit acc;
      test_reset();
      order_q.delete();
      @(negedge clk);
      st_req_valid = 1'b1; st_req_data = v_st;
      kw_req_valid = 1'b1; kw_req_data = v_kw;
      #1;
      checks++;
      if ({kw_req_ready, st_req_ready} !== 2'b10) begin
         errors++; $display("FAIL tie_grant: got kw/st=%b, want 10", {kw_req_ready, st_req_ready});
      end
      @(posedge clk);
      kw_exp_q.push_back(v_kw_exp);
      cyc = 0; acc = 1'b0;
      while (!acc && cyc < 20) begin
         @(negedge clk);
         kw_req_valid = 1'b0;
         #1;
         cyc++;
         if (st_req_ready) begin
            @(posedge clk);
            st_exp_q.push_back(v_st_exp);
            acc = 1'b1;
         end
      end
      @(negedge clk);
      st_req_valid = 1'b0;
      checks++;
      if (!acc || cyc != KwLat + 1) begin
         errors++; $display("FAIL tie_st_accept: got acc=%b cyc=%0d, want 1 %0d", acc, cyc, KwLat + 1);
      end
      for (int i = 0; i < 20 && st_exp_q.size() != 0; i++) @(negedge clk);
      #1;
      checks++;
      if (order_q.size() != 2 || order_q[0] != 1'b1 || order_q[1] != 1'b0) begin
         errors++; $display("FAIL tie_order: got %p, want key then state", order_q);
      end
   endtask

   task automatic test_fairness;
      bit grants[$];
      bit both_ready;
      int cyc;
      both_ready = 1'b0;
      cyc = 0;
      @(negedge clk);
      st_req_valid = 1'b1; st_req_data = {$urandom, $urandom, $urandom, $urandom};
      kw_req_valid = 1'b1; kw_req_data = $urandom;
      while (grants.size() < 4 && cyc < 100) begin
         #1;
         cyc++;
         if (st_req_ready && kw_req_ready) both_ready = 1'b1;
         if (kw_req_ready) begin
            grants.push_back(1'b1);
            kw_exp_q.push_back(sub_word(kw_req_data));
         end else if (st_req_ready) begin
            grants.push_back(1'b0);
            st_exp_q.push_back(sub_state(st_req_data));
         end
         @(negedge clk);
         if (grants.size() != 0 && cyc > 0) begin
            if (grants[grants.size()-1] && kw_req_ready === 1'b0 && busy) kw_req_data = $urandom;
            if (!grants[grants.size()-1] && st_req_ready === 1'b0 && busy)
               st_req_data = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      st_req_valid = 1'b0; kw_req_valid = 1'b0;
      for (int i = 0; i < 30 && (st_exp_q.size() != 0 || kw_exp_q.size() != 0); i++)
         @(negedge clk);
      checks++;
      if (grants.size() != 4 || both_ready) begin
         errors++;
         $display("FAIL fair_grants: got n=%0d both_ready=%b, want 4 0", grants.size(), both_ready);
      end
      for (int i = 0; i < grants.size(); i++) begin
         checks++;
         if (grants[i] != ((i % 2) == 0)) begin
            errors++; $display("FAIL fair_order[%0d]: got key=%b, want %b", i, grants[i], (i % 2) == 0);
         end
      end
   endtask

   task automatic test_reset_mid_job;
      int n;
      @(negedge clk);
      st_req_valid = 1'b1; st_req_data = v_st;
      @(posedge clk);
      st_exp_q.push_back(v_st_exp);
      repeat (3) begin
         @(negedge clk);
         st_req_valid = 1'b0;
      end
      #1;
      checks++;
      if (sbox_in !== v_st[63:32]) begin
         errors++; $display("FAIL mid_pass2: got %h, want %h", sbox_in, v_st[63:32]);
      end
      rst = 1'b1;
      #1;
      st_exp_q.delete();
      n = st_cnt;
      checks++;
      if ({st_req_ready, kw_req_ready, st_rsp_valid, kw_rsp_valid, busy} !== 5'b0 ||
          st_rsp_data !== 128'h0 || kw_rsp_data !== 32'h0 || sbox_in !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_vals: got flags=%b st=%h kw=%h in=%h, want zeros",
                  {st_req_ready, kw_req_ready, st_rsp_valid, kw_rsp_valid, busy}, st_rsp_data,
                  kw_rsp_data, sbox_in);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (st_cnt != n) begin
         errors++; $display("FAIL mid_no_rsp: got %0d responses, want %0d", st_cnt, n);
      end
      test_single_state();
   endtask

   task automatic test_request_during_busy;
      @(negedge clk);
      st_req_valid = 1'b1; st_req_data = v_st;
      @(posedge clk);
      st_exp_q.push_back(v_st_exp);
      for (int c = 1; c <= StLat + 2 + KwLat; c++) begin
         @(negedge clk);
         st_req_valid = 1'b0;
         if (c == 2) begin
            kw_req_valid = 1'b1; kw_req_data = v_kw;
         end
         if (c == StLat + 2) kw_req_valid = 1'b0;
         #1;
         if (c >= 2 && c <= StLat) begin
            checks++;
            if (kw_req_ready !== 1'b0 || busy !== 1'b1) begin
               errors++; $display("FAIL busy_hold c%0d: got ready=%b busy=%b, want 0 1", c,
                                  kw_req_ready, busy);
            end
         end else if (c == StLat + 1) begin
            checks++;
            if (kw_req_ready !== 1'b1 || busy !== 1'b0) begin
               errors++; $display("FAIL busy_idle c%0d: got ready=%b busy=%b, want 1 0", c,
                                  kw_req_ready, busy);
            end
            kw_exp_q.push_back(v_kw_exp);
         end else if (c > StLat + 1) begin
            checks++;
            if (busy !== (c != StLat + 2 + KwLat) || kw_rsp_valid !== (c == StLat + 2 + KwLat)) begin
               errors++; $display("FAIL busy_kw c%0d: got busy=%b valid=%b", c, busy, kw_rsp_valid);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (kw_exp_q.size() != 0 || st_exp_q.size() != 0) begin
         errors++; $display("FAIL busy_drain: got st=%0d kw=%0d pending, want 0 0",
                            st_exp_q.size(), kw_exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_state();
      test_single_key();
      test_tie_after_reset();
      test_fairness();
      test_reset_mid_job();
      test_request_during_busy();
      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

endmodule
